// File: rtl/sisr_pkg.sv
// Shared definitions for the serial-input signature register controller:
// FSM state encoding and signature width.
package sisr_pkg;

  localparam int unsigned SIG_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/sisr4b_en.sv
// 4-bit serial-input signature register, polynomial x^4 + x + 1,
// with synchronous clear and shift enable.
module sisr4b_en
  import sisr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             i,
  output logic [SIG_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[2], q[1], q[0] ^ q[3], i ^ q[3]};
    end
  end

endmodule

// File: rtl/sisr_ctrl.sv
// Run controller: compresses LEN serial bits into a 4-bit signature and
// compares it against a golden value captured when the run starts.
module sisr_ctrl
  import sisr_pkg::*;
#(
  parameter int unsigned LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] expected,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
);

  state_t           state, state_nx;
  logic [7:0]       cnt;
  logic [SIG_W-1:0] exp_q;
  logic             pass_q;
  logic             sig_clr, sig_en, cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      exp_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (sig_clr) begin
        cnt <= '0;
      end else if (sig_en) begin
        cnt <= cnt + 8'd1;
      end
      if (cap) begin
        exp_q <= expected;
      end
      if (abort || sig_clr) begin
        pass_q <= 1'b0;
      end else if (state == CHECK) begin
        pass_q <= (sig == exp_q);
      end
    end
  end

  // Abort overrides every other action, including bit acceptance and clear.
  always_comb begin
    state_nx = state;
    sig_clr  = 1'b0;
    sig_en   = 1'b0;
    cap      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          cap      = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        sig_clr  = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (bit_valid) begin
          sig_en = 1'b1;
          if (cnt == 8'(LEN - 1)) begin
            state_nx = CHECK;
          end
        end
      end
      CHECK: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      sig_clr  = 1'b0;
      sig_en   = 1'b0;
      cap      = 1'b0;
    end
  end

  sisr4b_en u_sisr (
    .clk (clk),
    .rst (rst),
    .clr (sig_clr),
    .en  (sig_en),
    .i   (bit_in),
    .q   (sig)
  );

  assign bit_ready = (state == SHIFT);
  assign busy      = (state == CLEAR) || (state == SHIFT) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = pass_q;

endmodule

// File: tb/tb_sisr_ctrl.sv
// Directed self-checking bench for sisr_ctrl with LEN=16.
module tb_sisr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] expected;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] sig;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  sisr_ctrl #(.LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .expected  (expected),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one run from start to done; bit i of stream is sent i-th.
  task automatic run(input string tag, input logic [15:0] stream, input bit gaps,
                     input logic [3:0] exp_in, input logic [3:0] sig_exp,
                     input logic pass_exp, input int lat_exp, input int poke_at);
    int n = 0;
    int acc = 0;
    int stall = 0;
    logic fire;
    logic [3:0] sig_hold;
    expected  = exp_in;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = stream[0];
    while ((n == 0 || !done) && n < 200) begin
      fire = bit_ready && bit_valid;
      if (busy && !bit_ready) stall++;
      tick();
      n++;
      if (fire) acc++;
      if (n == 1) begin
        expected = ~exp_in;
        chk({tag, "_clr_done"}, done, 1'b0);
        chk({tag, "_clr_busy"}, busy, 1'b1);
      end
      start = (n == poke_at);
      if (gaps) bit_valid = ~bit_valid;
      bit_in = bit_valid ? ((acc < 16) ? stream[acc] : 1'b0) : 1'b1;
    end
    start     = 1'b0;
    bit_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_sig"}, sig, sig_exp);
    chk({tag, "_pass"}, pass, pass_exp);
    chk({tag, "_accepts"}, acc, 16);
    chk({tag, "_nonready_busy"}, stall, 2);
    if (lat_exp > 0) chk({tag, "_latency"}, n, lat_exp);
    sig_hold = sig;
    tick();
    tick();
    chk({tag, "_hold_done"}, done, 1'b1);
    chk({tag, "_hold_sig"}, sig, sig_hold);
    chk({tag, "_hold_pass"}, pass, pass_exp);
  endtask

  // Starts a run and feeds stream bits until k have been accepted.
  task automatic run_partial(input logic [15:0] stream, input int k);
    int acc = 0;
    int n = 0;
    logic fire;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = stream[0];
    while (acc < k && n < 100) begin
      fire = bit_ready && bit_valid;
      tick();
      n++;
      start = 1'b0;
      if (fire) acc++;
      bit_in = stream[acc];
    end
    chk("partial_accepts", acc, k);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 4'h0;
    bit_in = 1'b0; bit_valid = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_ready", bit_ready, 1'b0);
    chk("rst_sig", sig, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run("one", 16'h0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 19, 0);
    run("zeros", 16'h0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 19, 0);
    run("gaps", 16'h0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 0, 0);

    // Abort with start and a valid 1-bit present: abort must win.
    run_partial(16'h0001, 5);
    abort = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_pass", pass, 1'b0);
    chk("abort_ready", bit_ready, 1'b0);
    chk("abort_sig", sig, 4'b0011);
    abort = 1'b0; start = 1'b0; bit_valid = 1'b0;
    tick();
    chk("abort_idle_busy", busy, 1'b0);
    run("restart", 16'h0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 19, 0);

    // Reset mid-SHIFT takes effect without waiting for a clock edge.
    run_partial(16'h00ff, 7);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_pass", pass, 1'b0);
    chk("mrst_ready", bit_ready, 1'b0);
    chk("mrst_sig", sig, 4'h0);
    start = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mrst_idle_done", done, 1'b0);

    run("poke", 16'h0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 19, 5);
    run("from_done", 16'h0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 19, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
